aes_inv_cipher_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 96 +++++++++
 rtl/aes_inv_cipher_iter_key_expand.sv | 24 ++
 rtl/aes_inv_cipher_iter.sv | 159 +++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte/state helpers for the iterative
// inverse cipher. Byte 0 of a 128-bit block sits in bits [127:120].
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYEXP = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } aes_state_e;

  // Entry 0 is unused; entries 1..10 feed key expansion steps 1..10.
  localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX_TBL[idx -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return INV_SBOX_TBL[idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the {0e,0b,0d,09} circulant matrix.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [0:3];
    logic [7:0] m9 [0:3];
    logic [7:0] mb [0:3];
    logic [7:0] md [0:3];
    logic [7:0] me [0:3];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    return r;
  endfunction

  // Row r of column c takes the byte from column (c - r) mod 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127 - 8*i -: 8] = s[127 - 8*((((i / 4) + 4 - (i % 4)) % 4) * 4 + (i % 4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_key_expand.sv
// Single AES-128 forward key-schedule step: RotWord, SubWord, rcon XOR and
// the word chain. Purely combinational.
module aes_key_expand_step
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] t_s, w0_s, w1_s, w2_s, w3_s;

  // Next four words from the previous round key
  always_comb begin
    t_s  = {sbox(prev_key[23:16]), sbox(prev_key[15:8]), sbox(prev_key[7:0]),
            sbox(prev_key[31:24])} ^ {rcon, 24'h000000};
    w0_s = prev_key[127:96] ^ t_s;
    w1_s = prev_key[95:64]  ^ w0_s;
    w2_s = prev_key[63:32]  ^ w1_s;
    w3_s = prev_key[31:0]   ^ w2_s;
    next_key = {w0_s, w1_s, w2_s, w3_s};
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, valid/ready on both
// sides. Round keys are expanded forward into an 11-entry store, then used
// in reverse. Optional feature macro: AES_INV_KEY_CACHE_EN (skip key
// expansion when the key repeats).
module aes_inv_cipher_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dataout
);

  aes_state_e   state_r, state_nxt_s;
  logic [127:0] rk_r [0:10];
  logic [127:0] blk_r, dataout_r, rk_next_s, rk_prev_s, ark_s, round_out_s;
  logic [3:0]   kcnt_r, rnd_r;
  logic         in_ready_r, out_valid_r;
  logic         hit_s, accept_s, kdone_s, rdone_s;
`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0] last_key_r;
  logic         cache_vld_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign dataout   = dataout_r;

  // Select the previous round key feeding the expansion step
  always_comb begin
    if (kcnt_r == 4'd0) rk_prev_s = rk_r[0];
    else                rk_prev_s = rk_r[kcnt_r - 4'd1];
  end

  aes_key_expand_step u_key_expand (
    .prev_key (rk_prev_s),
    .rcon     (RCON[kcnt_r]),
    .next_key (rk_next_s)
  );

  // Key-cache hit: same key as the last fully expanded one
  always_comb begin
    hit_s = 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
    if (cache_vld_r && (key == last_key_r)) hit_s = 1'b1;
    else                                     hit_s = 1'b0;
`endif
  end

  // One inverse round; the final round omits InvMixColumns
  always_comb begin
    ark_s = inv_sub_bytes(inv_shift_rows(blk_r)) ^ rk_r[rnd_r];
    if (rnd_r == 4'd0) round_out_s = ark_s;
    else               round_out_s = inv_mix_columns(ark_s);
  end

  // Next-state logic and per-state strobes
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    kdone_s     = 1'b0;
    rdone_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = hit_s ? ST_ROUND : ST_KEYEXP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_KEYEXP: begin
        if (kcnt_r == 4'd10) begin
          kdone_s     = 1'b1;
          state_nxt_s = ST_ROUND;
        end else begin
          state_nxt_s = ST_KEYEXP;
        end
      end
      ST_ROUND: begin
        if (rnd_r == 4'd0) begin
          rdone_s     = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ROUND;
        end
      end
      ST_DONE: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Datapath: block state, round-key store, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) rk_r[i] <= 128'd0;
      blk_r       <= 128'd0;
      dataout_r   <= 128'd0;
      kcnt_r      <= 4'd0;
      rnd_r       <= 4'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      if (accept_s && hit_s) begin
        blk_r <= datain ^ rk_r[10];
        rnd_r <= 4'd9;
      end else if (accept_s) begin
        blk_r   <= datain;
        rk_r[0] <= key;
        kcnt_r  <= 4'd1;
      end else if (state_r == ST_KEYEXP) begin
        rk_r[kcnt_r] <= rk_next_s;
        if (kdone_s) begin
          blk_r  <= blk_r ^ rk_next_s;
          rnd_r  <= 4'd9;
          kcnt_r <= 4'd0;
        end else begin
          kcnt_r <= kcnt_r + 4'd1;
        end
      end else if (state_r == ST_ROUND) begin
        blk_r <= round_out_s;
        if (rdone_s) dataout_r <= round_out_s;
        else         rnd_r     <= rnd_r - 4'd1;
      end
    end
  end

`ifdef AES_INV_KEY_CACHE_EN
  // Last-key register: refreshed on a miss, trusted once expansion completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_key_r  <= 128'd0;
      cache_vld_r <= 1'b0;
    end else if (accept_s && !hit_s) begin
      last_key_r  <= key;
      cache_vld_r <= 1'b0;
    end else if (kdone_s) begin
      cache_vld_r <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using FIPS-197 vectors: latency,
// backpressure, mid-operation reset, ignored input and key-cache reuse.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam int LAT_MISS = 20;
`ifdef AES_INV_KEY_CACHE_EN
  localparam int LAT_HIT = 10;
`else
  localparam int LAT_HIT = 20;
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] datain, key, dataout;
  int           nvec = 0;
  int           nmis = 0;

  always #5 clk = ~clk;

  aes_inv_cipher_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain    (datain),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataout   (dataout)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one block; optionally keep in_valid high with junk afterwards
  task automatic send(input logic [127:0] ct, input logic [127:0] k, input bit garbage);
    @(negedge clk);
    check_eq("in_ready_idle", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    datain   = ct;
    key      = k;
    @(posedge clk);
    #1;
    in_valid = garbage;
    datain   = garbage ? {$urandom, $urandom, $urandom, $urandom} : 128'd0;
    key      = garbage ? {$urandom, $urandom, $urandom, $urandom} : 128'd0;
  endtask

  // Count cycles from the accept edge to out_valid, then check the result
  task automatic await_result(input string tag, input int exp_lat,
                              input logic [127:0] exp_pt, input bit garbage);
    int lat = 0;
    bit got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        got = 1'b1;
      end else if (garbage) begin
        datain = {$urandom, $urandom, $urandom, $urandom};
        key    = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    in_valid = 1'b0;
    check_eq({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    check_eq({tag, "_pt"}, dataout, exp_pt);
    if (out_ready) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_ready_after"}, 128'(in_ready), 128'd1);
      check_eq({tag, "_valid_after"}, 128'(out_valid), 128'd0);
    end
  endtask

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; datain = 128'd0; key = 128'd0;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_in_ready", 128'(in_ready), 128'd1);
    check_eq("rst_out_valid", 128'(out_valid), 128'd0);
    check_eq("rst_dataout", dataout, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // C.1 with junk on the input during processing, cold cache
    send(C1_CT, C1_KEY, 1'b1);
    await_result("c1_first", LAT_MISS, C1_PT, 1'b1);
    // Same key again: cache hit when the cache is built in
    send(C1_CT, C1_KEY, 1'b0);
    await_result("c1_repeat", LAT_HIT, C1_PT, 1'b0);
    // Different key always expands
    send(B_CT, B_KEY, 1'b0);
    await_result("b_vec", LAT_MISS, B_PT, 1'b0);

    // Backpressure: result held with out_ready low
    out_ready = 1'b0;
    send(B_CT, B_KEY, 1'b0);
    await_result("bp", LAT_HIT, B_PT, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_data_hold", dataout, B_PT);
      check_eq("bp_valid_hold", 128'(out_valid), 128'd1);
      check_eq("bp_in_ready_low", 128'(in_ready), 128'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("bp_release_ready", 128'(in_ready), 128'd1);
    check_eq("bp_release_valid", 128'(out_valid), 128'd0);
    out_ready = 1'b1;

    // Reset while round 5 is in progress
    send(C1_CT, C1_KEY, 1'b0);
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 128'(out_valid), 128'd0);
    check_eq("midrst_in_ready", 128'(in_ready), 128'd1);
    check_eq("midrst_dataout", dataout, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Cache was invalidated by reset, so full expansion again
    send(C1_CT, C1_KEY, 1'b0);
    await_result("c1_after_rst", LAT_MISS, C1_PT, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
